match_flow_ctrl: RTL and testbench
==================================

MATCH_FLOW_CTRL -- requirements
Module: match_flow_ctrl

Interface
REQ-001 Parameter N_ROUNDS, default 5, regulation shots per side (1..15).
REQ-002 Parameter SCORE_W, default 4, width of score and round counters.
REQ-003 Parameter START_AS_KEEPER, default 1; in multi mode, 1 = player opens as keeper, 0 = as shooter.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 left_clicked  in  1  one-cycle pulse, starts match.
REQ-007 right_clicked  in  1  one-cycle pulse, returns from result screen.
REQ-008 solo_enable  in  1  mode select, sampled only in START.
REQ-009 connect_ok  in  1  multi-mode link healthy.
REQ-010 shot_done  in  1  one-cycle pulse, current shot resolved.
REQ-011 shot_goal  in  1  qualifies shot_done: 1 = goal scored, 0 = saved/missed.
REQ-012 game_state  out  g_state  current state (START, KEEPER, SHOOTER, WINNER, LOSER).
REQ-013 game_mode  out  g_mode  latched mode (SOLO, MULTI).
REQ-014 player_score, opp_score  out  SCORE_W  running scores.
REQ-015 round_cnt  out  SCORE_W  completed rounds.
REQ-016 match_end  out  1  one-cycle pulse on entry to WINNER or LOSER.
REQ-017 match_result  out  1  1 = player won; held until next match start.

Function
REQ-018 All outputs registered; an input event changes outputs on the next rising clk edge.
REQ-019 START: game_mode <= SOLO if solo_enable else MULTI each cycle; on left_clicked (multi also needs connect_ok) clear scores and round_cnt, go KEEPER (solo, or multi with START_AS_KEEPER=1) else SHOOTER.
REQ-020 Solo: state stays KEEPER; shot_done with shot_goal=1 increments opp_score, with 0 increments player_score; every shot_done increments round_cnt.
REQ-021 Multi KEEPER: goal increments opp_score; multi SHOOTER: goal increments player_score; each shot_done toggles KEEPER/SHOOTER; round_cnt increments after the second shot of a pair.
REQ-022 Early decision: after each counted shot, if player_score > opp_score + opp_remaining go WINNER; if opp_score > player_score + player_remaining go LOSER (remaining = regulation shots not yet taken by that side; solo: remaining rounds for both).
REQ-023 After regulation with scores equal, behaviour per Configuration.
REQ-024 WINNER/LOSER: hold until right_clicked, then START; scores and match_result frozen meanwhile.
REQ-025 Multi KEEPER/SHOOTER with connect_ok=0: go START next edge; same-cycle shot_done ignored.
REQ-026 shot_done outside KEEPER/SHOOTER ignored; left_clicked outside START ignored; right_clicked outside WINNER/LOSER ignored.
REQ-027 Counters saturate at 2**SCORE_W-1, never wrap.
REQ-028 match_result <= 1 on WINNER entry, 0 on LOSER entry, cleared on match start.
REQ-029 Illegal state encoding goes to START next edge.

Reset
REQ-030 rst low: immediately game_state=START, game_mode=MULTI, scores=0, round_cnt=0, match_end=0, match_result=0; applies mid-match too.
REQ-031 Release synchronous to clk is the integrator's duty; first transition is no earlier than the first edge after release.

Configuration
REQ-032 Macro MATCH_SUDDEN_DEATH_EN defined: regulation tie continues one round at a time (solo: decided after one shot; multi: decided after each completed pair if scores differ), until decision.
REQ-033 Macro undefined: regulation tie goes LOSER with match_result=0.

Verification
REQ-034 Solo, N_ROUNDS=5: left_clicked, shots save,save,save,goal -> WINNER after 3rd save (3-0, 2 remaining), match_end one pulse, round_cnt=3.
REQ-035 Multi, START_AS_KEEPER=1, connect_ok=1: 5 pairs alternating, 3-3 after 5 rounds -> with macro: continue; pair goal/save -> WINNER 4-3; without macro: LOSER.
REQ-036 Multi mid-match: connect_ok drops in same cycle as shot_done -> START next edge, scores unchanged by that shot.
REQ-037 rst asserted while KEEPER with score 2-1 -> all outputs reset values immediately without clk edge.
REQ-038 solo_enable toggled during KEEPER -> game_mode unchanged; right_clicked in WINNER -> START, match_result held until left_clicked.

Source files
------------

// File: rtl/match_flow_ctrl.sv
// Penalty-shootout match sequencer: start/keeper/shooter/result flow, scoring and early decision.
// Build option MATCH_SUDDEN_DEATH_EN: a tie after regulation continues round by round instead of losing.
package match_flow_pkg;
  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOSER   = 3'd4
  } g_state;

  typedef enum logic {
    MULTI = 1'b0,
    SOLO  = 1'b1
  } g_mode;
endpackage

module match_flow_ctrl
  import match_flow_pkg::*;
#(
  parameter int unsigned N_ROUNDS        = 5,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned START_AS_KEEPER = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               left_clicked,
  input  logic               right_clicked,
  input  logic               solo_enable,
  input  logic               connect_ok,
  input  logic               shot_done,
  input  logic               shot_goal,
  output g_state             game_state,
  output g_mode              game_mode,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] opp_score,
  output logic [SCORE_W-1:0] round_cnt,
  output logic               match_end,
  output logic               match_result
);

`ifdef MATCH_SUDDEN_DEATH_EN
  localparam bit SUDDEN_DEATH = 1'b1;
`else
  localparam bit SUDDEN_DEATH = 1'b0;
`endif

  // Decision arithmetic is kept wide enough for N_ROUNDS even when SCORE_W is small.
  localparam int unsigned CW   = ((SCORE_W > 4) ? SCORE_W : 4) + 2;
  localparam logic [CW-1:0] N_CW = CW'(N_ROUNDS);
  localparam logic [SCORE_W-1:0] CNT_MAX = '1;

  g_state             state_q, state_d;
  g_mode              mode_q, mode_d;
  logic [SCORE_W-1:0] p_score_q, p_score_d, o_score_q, o_score_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] p_shots_q, p_shots_d, o_shots_q, o_shots_d;
  logic               half_q, half_d;
  logic               end_q, end_d;
  logic               result_q, result_d;

  logic [SCORE_W-1:0] p_new, o_new, psh_new, osh_new, round_new;
  logic               half_new, pair_done, win, lose, tie_end, is_solo;
  logic [CW-1:0]      target, rem_p, rem_o;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Outcome of a shot resolved this cycle; only consumed by the FSM when one is accepted.
  always_comb begin
    is_solo   = (mode_q == SOLO);
    p_new     = p_score_q;
    o_new     = o_score_q;
    psh_new   = p_shots_q;
    osh_new   = o_shots_q;
    round_new = round_q;
    half_new  = 1'b0;
    pair_done = 1'b1;
    if (is_solo) begin
      if (shot_goal) o_new = sat_inc(o_score_q);
      else           p_new = sat_inc(p_score_q);
      psh_new   = sat_inc(p_shots_q);
      osh_new   = sat_inc(o_shots_q);
      round_new = sat_inc(round_q);
    end else begin
      if (state_q == KEEPER) begin
        if (shot_goal) o_new = sat_inc(o_score_q);
        osh_new = sat_inc(o_shots_q);
      end else begin
        if (shot_goal) p_new = sat_inc(p_score_q);
        psh_new = sat_inc(p_shots_q);
      end
      half_new  = ~half_q;
      pair_done = half_q;
      if (half_q) round_new = sat_inc(round_q);
    end
    // Past regulation the side yet to shoot in the open pair still owns one shot.
    target = N_CW;
    if (CW'(psh_new) > target) target = CW'(psh_new);
    if (CW'(osh_new) > target) target = CW'(osh_new);
    rem_p   = target - CW'(psh_new);
    rem_o   = target - CW'(osh_new);
    win     = CW'(p_new) > (CW'(o_new) + rem_o);
    lose    = CW'(o_new) > (CW'(p_new) + rem_p);
    tie_end = pair_done && (CW'(psh_new) >= N_CW) && (CW'(osh_new) >= N_CW) && (p_new == o_new);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    p_score_d = p_score_q;
    o_score_d = o_score_q;
    round_d   = round_q;
    p_shots_d = p_shots_q;
    o_shots_d = o_shots_q;
    half_d    = half_q;
    end_d     = 1'b0;
    result_d  = result_q;
    case (state_q)
      START: begin
        mode_d = solo_enable ? SOLO : MULTI;
        if (left_clicked && (solo_enable || connect_ok)) begin
          p_score_d = '0;
          o_score_d = '0;
          round_d   = '0;
          p_shots_d = '0;
          o_shots_d = '0;
          half_d    = 1'b0;
          result_d  = 1'b0;
          state_d   = (solo_enable || (START_AS_KEEPER != 0)) ? KEEPER : SHOOTER;
        end
      end
      KEEPER, SHOOTER: begin
        if (!is_solo && !connect_ok) begin
          state_d = START;
        end else if (shot_done) begin
          p_score_d = p_new;
          o_score_d = o_new;
          round_d   = round_new;
          p_shots_d = psh_new;
          o_shots_d = osh_new;
          half_d    = half_new;
          if (win) begin
            state_d  = WINNER;
            end_d    = 1'b1;
            result_d = 1'b1;
          end else if (lose || (tie_end && !SUDDEN_DEATH)) begin
            state_d  = LOSER;
            end_d    = 1'b1;
            result_d = 1'b0;
          end else if (is_solo) begin
            state_d = KEEPER;
          end else begin
            state_d = (state_q == KEEPER) ? SHOOTER : KEEPER;
          end
        end
      end
      WINNER, LOSER: begin
        if (right_clicked) state_d = START;
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= START;
      mode_q    <= MULTI;
      p_score_q <= '0;
      o_score_q <= '0;
      round_q   <= '0;
      p_shots_q <= '0;
      o_shots_q <= '0;
      half_q    <= 1'b0;
      end_q     <= 1'b0;
      result_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      p_score_q <= p_score_d;
      o_score_q <= o_score_d;
      round_q   <= round_d;
      p_shots_q <= p_shots_d;
      o_shots_q <= o_shots_d;
      half_q    <= half_d;
      end_q     <= end_d;
      result_q  <= result_d;
    end
  end

  assign game_state   = state_q;
  assign game_mode    = mode_q;
  assign player_score = p_score_q;
  assign opp_score    = o_score_q;
  assign round_cnt    = round_q;
  assign match_end    = end_q;
  assign match_result = result_q;

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Directed bench for match_flow_ctrl: solo win/lose, multi regulation tie, link loss, async reset.
module tb_match_flow_ctrl;
  import match_flow_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       left_clicked, right_clicked, solo_enable, connect_ok, shot_done, shot_goal;
  g_state     game_state;
  g_mode      game_mode;
  logic [3:0] player_score, opp_score, round_cnt;
  logic       match_end, match_result;

  int total = 0;
  int bad   = 0;

  match_flow_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .left_clicked (left_clicked),
    .right_clicked(right_clicked),
    .solo_enable  (solo_enable),
    .connect_ok   (connect_ok),
    .shot_done    (shot_done),
    .shot_goal    (shot_goal),
    .game_state   (game_state),
    .game_mode    (game_mode),
    .player_score (player_score),
    .opp_score    (opp_score),
    .round_cnt    (round_cnt),
    .match_end    (match_end),
    .match_result (match_result)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input g_state st, input logic [3:0] ps,
                         input logic [3:0] os, input logic [3:0] rc);
    chk({tag, "_state"}, game_state, st);
    chk({tag, "_pscore"}, player_score, ps);
    chk({tag, "_oscore"}, opp_score, os);
    chk({tag, "_round"}, round_cnt, rc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_all(tag, START, 4'd0, 4'd0, 4'd0);
    chk({tag, "_mode"}, game_mode, MULTI);
    chk({tag, "_end"}, match_end, 1'b0);
    chk({tag, "_result"}, match_result, 1'b0);
  endtask

  task automatic left_pulse();
    left_clicked = 1'b1;
    tick();
    left_clicked = 1'b0;
  endtask

  task automatic right_pulse();
    right_clicked = 1'b1;
    tick();
    right_clicked = 1'b0;
  endtask

  task automatic shot(input logic goal);
    shot_done = 1'b1;
    shot_goal = goal;
    tick();
    shot_done = 1'b0;
    shot_goal = 1'b0;
  endtask

  initial begin
    logic [4:0] k_goal;
    logic [4:0] s_goal;
    rst = 1'b0;
    left_clicked = 1'b0; right_clicked = 1'b0; solo_enable = 1'b0;
    connect_ok = 1'b1; shot_done = 1'b0; shot_goal = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk) rst = 1'b1;
    tick();

    // Solo: three saves decide the match 3-0 with two rounds left.
    solo_enable = 1'b1;
    tick();
    chk("solo_mode", game_mode, SOLO);
    left_pulse();
    chk_all("solo_start", KEEPER, 4'd0, 4'd0, 4'd0);
    shot(1'b0);
    chk_all("solo_s1", KEEPER, 4'd1, 4'd0, 4'd1);
    solo_enable = 1'b0;
    tick();
    chk("solo_mode_held", game_mode, SOLO);
    solo_enable = 1'b1;
    shot(1'b0);
    chk_all("solo_s2", KEEPER, 4'd2, 4'd0, 4'd2);
    shot(1'b0);
    chk_all("solo_win", WINNER, 4'd3, 4'd0, 4'd3);
    chk("solo_win_end", match_end, 1'b1);
    chk("solo_win_result", match_result, 1'b1);
    shot(1'b1);
    chk_all("solo_post_shot", WINNER, 4'd3, 4'd0, 4'd3);
    chk("solo_end_pulse", match_end, 1'b0);
    left_pulse();
    chk("solo_left_ignored", game_state, WINNER);
    right_pulse();
    chk("solo_back_start", game_state, START);
    chk("solo_result_held", match_result, 1'b1);
    left_pulse();
    chk_all("solo_restart", KEEPER, 4'd0, 4'd0, 4'd0);
    chk("solo_result_clr", match_result, 1'b0);

    // Solo: three goals against lose 0-3.
    shot(1'b1);
    shot(1'b1);
    chk_all("solo_g2", KEEPER, 4'd0, 4'd2, 4'd2);
    shot(1'b1);
    chk_all("solo_lose", LOSER, 4'd0, 4'd3, 4'd3);
    chk("solo_lose_end", match_end, 1'b1);
    chk("solo_lose_result", match_result, 1'b0);
    right_pulse();
    chk("solo_lose_back", game_state, START);

    // Multi: start refused without link, then five pairs to 3-3.
    solo_enable = 1'b0;
    connect_ok = 1'b0;
    tick();
    chk("multi_mode", game_mode, MULTI);
    left_pulse();
    chk("multi_no_link", game_state, START);
    connect_ok = 1'b1;
    left_pulse();
    chk_all("multi_start", KEEPER, 4'd0, 4'd0, 4'd0);
    k_goal = 5'b00111;
    s_goal = 5'b00111;
    for (int i = 0; i < 5; i++) begin
      shot(k_goal[i]);
      chk("multi_after_keeper", game_state, SHOOTER);
      shot(s_goal[i]);
      if (i < 4) chk("multi_after_shooter", game_state, KEEPER);
    end
`ifdef MATCH_SUDDEN_DEATH_EN
    chk_all("multi_tie_cont", KEEPER, 4'd3, 4'd3, 4'd5);
    shot(1'b0);
    chk_all("multi_sd_half", SHOOTER, 4'd3, 4'd3, 4'd5);
    shot(1'b1);
    chk_all("multi_sd_win", WINNER, 4'd4, 4'd3, 4'd6);
    chk("multi_sd_result", match_result, 1'b1);
`else
    chk_all("multi_tie_lose", LOSER, 4'd3, 4'd3, 4'd5);
    chk("multi_tie_result", match_result, 1'b0);
`endif
    chk("multi_end_pulse", match_end, 1'b1);
    right_pulse();
    chk("multi_back_start", game_state, START);

    // Multi: link drops in the same cycle as a goal.
    left_pulse();
    shot(1'b1);
    chk_all("link_pre", SHOOTER, 4'd0, 4'd1, 4'd0);
    connect_ok = 1'b0;
    shot(1'b1);
    chk_all("link_drop", START, 4'd0, 4'd1, 4'd0);
    connect_ok = 1'b1;

    // Multi to 2-1, stray clicks ignored, then async reset mid-cycle.
    left_pulse();
    shot(1'b1);
    shot(1'b1);
    shot(1'b0);
    shot(1'b1);
    chk_all("pre_reset", KEEPER, 4'd2, 4'd1, 4'd2);
    right_pulse();
    left_pulse();
    chk_all("stray_clicks", KEEPER, 4'd2, 4'd1, 4'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk) rst = 1'b1;
    tick();
    chk("post_release", game_state, START);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
